mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; `clk` is the sole clock and `rst` is the synchronous, active-high reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation:
  - 00 MULTU
  - 01 MULT (signed)
  - 10 DIVU
  - 11 DIV (signed)
- A  in  32  operand 1 (register-file DR1)
- B  in  32  operand 2 (register-file DR2)
- HI  out  32  product high word / remainder
- LO  out  32  product low word / quotient
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- dz  out  1  last completed op was a divide by zero

Function
REQ-003 The block SHALL implement states IDLE, CALC and FIN:
- IDLE→CALC on start=1.
- IDLE→FIN on start=1 with a divide op and B==0.
- CALC→FIN after iteration 32.
- FIN→IDLE unconditionally.
REQ-004 On the accepting edge, the block SHALL latch A, B and op internally; changes to A, B, op during CALC/FIN SHALL have no effect.
REQ-005 start asserted in CALC or FIN SHALL be ignored, not queued.
REQ-006 busy SHALL be 1 exactly while in CALC; done SHALL be 1 exactly while in FIN.
REQ-007 Normal latency SHALL be fixed: start sampled at edge 0, CALC for 32 cycles, done=1 in the 33rd cycle after the accepting edge, IDLE in the 34th.
REQ-008 Multiply SHALL be iterative shift-add, one operand bit per CALC cycle.
REQ-009 At the CALC→FIN edge, multiply SHALL load {HI,LO} with the full 64-bit product.
REQ-010 MULT SHALL multiply the magnitudes of A and B, then two's-complement-negate the 64-bit result when A[31]^B[31]=1.
REQ-011 Divide SHALL be iterative restoring division, one quotient bit per CALC cycle.
REQ-012 At the CALC→FIN edge, divide SHALL load LO with the quotient and HI with the remainder.
REQ-013 DIV SHALL operate on magnitudes:
- Quotient is negated when A[31]^B[31]=1.
- Remainder is negated when A[31]=1, so its sign equals the dividend's.
REQ-014 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, dz=0; this is the natural magnitude result and needs no special trap.
REQ-015 A divide with B==0 SHALL skip CALC and enter FIN on the accepting edge; done then goes high in the following cycle, with latency 1.
REQ-016 At that same accepting edge the divide-by-zero case SHALL load HI=A, LO=0xFFFFFFFF, dz=1.
REQ-017 dz SHALL be cleared to 0 on every other completion.
REQ-018 HI, LO and dz SHALL change only on a completion edge (entry to FIN) or reset, and SHALL hold between operations.
REQ-019 Partial results SHALL NOT be visible on HI/LO during CALC.
REQ-020 The iteration counter SHALL be 6 bits wide, count 0..31 in CALC, and be reset to 0 on each accept.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL go to IDLE and set HI=0, LO=0, busy=0, done=0, dz=0, counter=0; this takes priority over start and over any state.
REQ-022 Reset during CALC or FIN SHALL abort the operation with no completion pulse and no HI/LO update beyond the reset values.
REQ-023 start asserted in the same cycle as rst SHALL be ignored.
REQ-024 The first start SHALL be accepted in the first cycle with rst=0.

Verification
REQ-025 The bench SHALL check MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → done 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001, dz=0; busy high for exactly 32 cycles.
REQ-026 The bench SHALL check MULT A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1 (-15).
REQ-027 The bench SHALL check DIVU A=100, B=7 → LO=14, HI=2.
REQ-028 The bench SHALL check DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-029 The bench SHALL check DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
REQ-030 The bench SHALL check DIVU A=0x12345678, B=0 → done in the cycle after start, busy never 1; HI=0x12345678, LO=0xFFFFFFFF, dz=1.
REQ-031 The bench SHALL check that a following MULTU 2×3 clears dz to 0.
REQ-032 The bench SHALL check MULTU 6×7 with start re-pulsed and A/B changed at cycle 10 → result HI=0, LO=42 at cycle 33, second start ignored.
REQ-033 The bench SHALL check rst=1 at cycle 15 of that multiply → next cycle IDLE, HI=LO=0, no done pulse.
REQ-034 The bench SHALL check that a new start then completes normally.

Source files
------------

// File: rtl/mult_div.sv
// mult_div: iterative 32x32 multiply / divide unit.
//
// A request is accepted in IDLE when start=1. The operands and operation are
// latched and the unit runs 32 CALC cycles, one operand/quotient bit per
// cycle. On the CALC->FIN edge the result is written to HI/LO. done pulses for
// the single FIN cycle. A divide by zero bypasses CALC, entering FIN directly
// with HI=A, LO=0xFFFFFFFF, dz=1.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B   operands
//   HI     product high word / remainder
//   LO     product low word / quotient
//   busy   high while in CALC
//   done   high while in FIN (one cycle)
//   dz     last completed operation was a divide by zero
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;

  // Latched operation context (data path, not reset)
  logic        r_is_div;
  logic        r_neg_lo;   // negate product / quotient at the end
  logic        r_neg_hi;   // negate remainder at the end (signed divide only)
  logic [31:0] r_b_mag;    // multiplicand / divisor magnitude
  logic [31:0] r_hi_w;     // running product high word / partial remainder
  logic [31:0] r_lo_w;     // multiplier bits / dividend bits shifting into quotient

  logic        w_accept;
  logic        w_div_zero;
  logic        w_last;
  logic [32:0] w_mul_sum;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [31:0] w_div_q;
  logic [31:0] w_step_hi;
  logic [31:0] w_step_lo;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // Magnitude of a value; only treated as signed when sgn=1.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_div_zero = op[1] && (B == 32'd0);
  assign w_last     = (r_cnt == 6'd31);

  always_comb begin
    // Shift-add multiply: add multiplicand into the high word when the
    // current multiplier LSB is set, then shift {carry,hi,lo} right by one.
    w_mul_sum = {1'b0, r_hi_w} + (r_lo_w[0] ? {1'b0, r_b_mag} : 33'd0);
    w_mul_hi  = w_mul_sum[32:1];
    w_mul_lo  = {w_mul_sum[0], r_lo_w[31:1]};

    // Restoring divide: bring in the next dividend bit, subtract the divisor
    // if it fits. The partial remainder is always below the divisor, so both
    // the kept and the subtracted value fit in 32 bits.
    w_div_shift = {r_hi_w, r_lo_w[31]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
    w_div_rem   = w_div_ge ? (w_div_shift[31:0] - r_b_mag) : w_div_shift[31:0];
    w_div_q     = {r_lo_w[30:0], w_div_ge};

    w_step_hi = r_is_div ? w_div_rem : w_mul_hi;
    w_step_lo = r_is_div ? w_div_q   : w_mul_lo;

    // Sign fix-up applied to the final iteration's result
    if (r_is_div) begin
      w_res_hi = f_neg32(w_step_hi, r_neg_hi);
      w_res_lo = f_neg32(w_step_lo, r_neg_lo);
    end else begin
      {w_res_hi, w_res_lo} = f_neg64({w_step_hi, w_step_lo}, r_neg_lo);
    end
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt <= 6'd0;
            if (w_div_zero) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_hi    <= A;
              r_lo    <= 32'hFFFF_FFFF;
              r_dz    <= 1'b1;
            end else begin
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (w_last) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_dz    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Iteration data path
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= op[1];
      r_neg_lo <= op[0] && (A[31] ^ B[31]);
      r_neg_hi <= op[0] && op[1] && A[31];
      r_b_mag  <= f_mag(B, op[0]);
      r_hi_w   <= 32'd0;
      r_lo_w   <= f_mag(A, op[0]);
    end else if (r_state == ST_CALC) begin
      r_hi_w <= w_step_hi;
      r_lo_w <= w_step_lo;
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        dz;

  mult_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  // Reference arithmetic straight from the operation definitions
  function automatic res_t ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r.dz = 1'b0;
    r.hi = 32'd0;
    r.lo = 32'd0;
    case (o)
      2'b00: begin
        up = {32'd0, a} * {32'd0, b};
        {r.hi, r.lo} = up;
      end
      2'b01: begin
        sp = sa * sb;
        {r.hi, r.lo} = sp;
      end
      default: begin
        if (b == 32'd0) begin
          r.dz = 1'b1;
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          r.lo = a / b;
          r.hi = a % b;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r.lo = sq[31:0];
          r.hi = sr[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Cycle-level model: cycles of work left, done flag, visible results
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  res_t        m_pend;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_left = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        {m_dz, m_hi, m_lo} = m_pend;
      end
    end else if (start === 1'b1) begin
      m_pend = ref_calc(op, A, B);
      if (op[1] && B == 32'd0) begin
        m_done = 1'b1;
        {m_dz, m_hi, m_lo} = m_pend;
      end else begin
        m_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc busy", 64'(busy), 64'(m_left > 0));
      check("cyc done", 64'(done), 64'(m_done));
      check("cyc HI",   64'(HI),   64'(m_hi));
      check("cyc LO",   64'(LO),   64'(m_lo));
      check("cyc dz",   64'(dz),   64'(m_dz));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Issue one operation; operands and start are scrambled while it runs,
  // including a start re-pulse in cycle 10.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit lit, input logic [31:0] eh,
                        input logic [31:0] el, input logic edz);
    int   lat;
    int   bc;
    int   elat;
    int   ebc;
    res_t r;
    elat = (o[1] && b == 32'd0) ? 1 : 33;
    ebc  = (elat == 33) ? 32 : 0;
    if (lit) begin
      r.dz = edz;
      r.hi = eh;
      r.lo = el;
    end else begin
      r = ref_calc(o, a, b);
    end
    @(negedge clk);
    rst = 1'b0; op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      start = (lat == 10) || ($urandom_range(0, 3) == 0);
      A  = $urandom;
      B  = $urandom;
      op = 2'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({nm, " latency"},   64'(lat), 64'(elat));
    check({nm, " busy_cyc"},  64'(bc),  64'(ebc));
    check({nm, " HI"},        64'(HI),  64'(r.hi));
    check({nm, " LO"},        64'(LO),  64'(r.lo));
    check({nm, " dz"},        64'(dz),  64'(r.dz));
    @(posedge clk); #1;
    check({nm, " idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    res_t pr;
    bit   seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset with a start request pending; it must be ignored
    rst = 1'b1; start = 1'b1; op = 2'b00; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst HI",   64'(HI),   64'd0);
    check("rst LO",   64'(LO),   64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz",   64'(dz),   64'd0);

    // Pin the reference arithmetic against hand-computed values
    pr = ref_calc(2'b01, 32'hFFFF_FFFD, 32'd5);
    check("ref mult", {pr.hi, pr.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    pr = ref_calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ref div ovf", {pr.hi, pr.lo}, 64'h0000_0000_8000_0000);
    pr = ref_calc(2'b11, 32'hFFFF_FFF9, 32'd2);
    check("ref div neg", {pr.hi, pr.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    pr = ref_calc(2'b10, 32'd100, 32'd7);
    check("ref divu", {pr.hi, pr.lo}, 64'h0000_0002_0000_000E);

    // start already high as rst drops: accepted on the first rst=0 edge
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("divu",      2'b10, 32'd100,       32'd7,         1'b1, 32'd2,         32'd14,        1'b0);
    run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, 1'b0);
    run_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0,         1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_2x3", 2'b00, 32'd2,         32'd3,         1'b1, 32'd0,         32'd6,         1'b0);
    run_op("multu_6x7", 2'b00, 32'd6,         32'd7,         1'b1, 32'd0,         32'd42,        1'b0);

    // Abort a multiply with reset in cycle 15
    @(negedge clk);
    op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort HI",   64'(HI),   64'd0);
    check("abort LO",   64'(LO),   64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort no_done", 64'(seen_done), 64'd0);

    run_op("after_abort", 2'b00, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);

    // Randomised operations against the reference arithmetic
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op("rand", ro, ra, rb, 1'b0, 32'd0, 32'd0, 1'b0);
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
